bit_serializer: RTL and testbench

Parallel-to-serial front end for the Mealy pattern detector. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `d_o`/`valid_o`, which connect directly to the detector's `d_i`/`valid_i`. A downstream `pause_i` holds the stream without losing bits; `last_o` marks the final bit of each word for scoreboarding.

---
 rtl/bit_ser_pkg.sv | 25 ++
 rtl/bit_serializer.sv | 95 +++++++++
 tb/tb_bit_serializer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bit_ser_pkg.sv
// Shared types and sizing helpers for the bit serializer.
// BIT_SERIALIZER_PARITY_EN adds one trailing even-parity bit to every word.
package bit_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int bits_per_word(input int width);
        return width + PARITY_BITS;
    endfunction

    // Counter must hold up to WIDTH+1 remaining bits when parity is enabled.
    function automatic int rem_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: valid/ready word in, one registered bit per clock out.
// Build option BIT_SERIALIZER_PARITY_EN appends an even-parity bit after each word.
module bit_serializer
    import bit_ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             pause_i,
    output logic             d_o,
    output logic             valid_o,
    output logic             last_o
);

    localparam int BITS_PER_WORD = bits_per_word(WIDTH);
    localparam int CW            = rem_width(WIDTH);
    localparam logic [CW-1:0] REM_LOAD = CW'(BITS_PER_WORD - 1);
    localparam logic [CW-1:0] REM_ONE  = CW'(1);

    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    rem;
    state_t           state;

    logic             first_bit;
    logic             next_bit;
    logic             emit_bit;
    logic [WIDTH-1:0] load_sh;
    logic [WIDTH-1:0] shift_sh;

    assign state   = (rem == '0) ? IDLE : SHIFT;
    assign ready_o = (state == IDLE) && !pause_i;

    always_comb begin
        if (MSB_FIRST) begin
            first_bit = data_i[WIDTH-1];
            load_sh   = data_i << 1;
            next_bit  = sh[WIDTH-1];
            shift_sh  = sh << 1;
        end else begin
            first_bit = data_i[0];
            load_sh   = data_i >> 1;
            next_bit  = sh[0];
            shift_sh  = sh >> 1;
        end
    end

`ifdef BIT_SERIALIZER_PARITY_EN
    logic par_q;

    // The final counted position carries the parity bit instead of data.
    assign emit_bit = (rem == REM_ONE) ? par_q : next_bit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else if (valid_i && ready_o) begin
            par_q <= ^data_i;
        end
    end
`else
    assign emit_bit = next_bit;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh      <= '0;
            rem     <= '0;
            d_o     <= 1'b0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
        end else if (valid_i && ready_o) begin
            d_o     <= first_bit;
            valid_o <= 1'b1;
            last_o  <= 1'b0;
            sh      <= load_sh;
            rem     <= REM_LOAD;
        end else if (state == SHIFT && !pause_i) begin
            d_o     <= emit_bit;
            valid_o <= 1'b1;
            last_o  <= (rem == REM_ONE);
            sh      <= shift_sh;
            rem     <= rem - REM_ONE;
        end else begin
            // Paused or idle: hold position and d_o, drop the qualifiers.
            valid_o <= 1'b0;
            last_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed vector bench for bit_serializer (MSB-first instance plus an LSB-first instance).
module tb_bit_serializer;

    typedef struct {
        logic       rst;
        logic       vin;
        logic [7:0] data;
        logic       pause;
        logic       chk_rdy;
        logic       rdy;
        logic       v;
        logic       d;
        logic       l;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_m, data_l;
    logic       valid_m, valid_l;
    logic       pause_m, pause_l;
    logic       ready_m, ready_l;
    logic       d_m, d_l;
    logic       vo_m, vo_l;
    logic       last_m, last_l;

    int passed = 0;
    int total  = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .data_i(data_m), .valid_i(valid_m), .ready_o(ready_m),
        .pause_i(pause_m), .d_o(d_m), .valid_o(vo_m), .last_o(last_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .data_i(data_l), .valid_i(valid_l), .ready_o(ready_l),
        .pause_i(pause_l), .d_o(d_l), .valid_o(vo_l), .last_o(last_l)
    );

    function automatic void add(input logic r, input logic vin, input logic [7:0] data,
                                input logic pause, input logic chk_rdy, input logic rdy,
                                input logic v, input logic d, input logic l);
        vec_t e;
        e.rst = r; e.vin = vin; e.data = data; e.pause = pause; e.chk_rdy = chk_rdy;
        e.rdy = rdy; e.v = v; e.d = d; e.l = l;
        vecs.push_back(e);
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b", name, act, exp);
        else
            passed++;
    endtask

    initial begin
        rst = 1'b0; data_m = '0; valid_m = 1'b0; pause_m = 1'b0;
        data_l = '0; valid_l = 1'b0; pause_l = 1'b0;

        // rst vin data pause chk_rdy rdy | v d l
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0, 0, 0);
`ifndef BIT_SERIALIZER_PARITY_EN
        // single word B4 -> 1,0,1,1,0,1,0,0
        add(1, 1, 8'hB4, 0, 1, 1, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 1);
        add(1, 0, 8'h00, 0, 1, 1, 0, 0, 0);
        // back-to-back FF then 00, valid held high
        add(1, 1, 8'hFF, 0, 1, 1, 1, 1, 0);
        for (int k = 0; k < 6; k++) add(1, 1, 8'h00, 0, 1, 0, 1, 1, 0);
        add(1, 1, 8'h00, 0, 1, 0, 1, 1, 1);
        add(1, 1, 8'h00, 0, 1, 1, 1, 0, 0);
        for (int k = 0; k < 6; k++) add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 1);
        add(1, 0, 8'h00, 0, 1, 1, 0, 0, 0);
        // A5 with a 3-cycle pause after the 4th bit
        add(1, 1, 8'hA5, 0, 1, 1, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 8'h00, 1, 1, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 1, 1);
        // idle but paused: no acceptance
        add(1, 1, 8'h00, 1, 1, 0, 0, 1, 0);
        add(1, 0, 8'h00, 0, 1, 1, 0, 1, 0);
        // reset after 3rd bit of C3, reset wins over a handshake
        add(1, 1, 8'hC3, 0, 1, 1, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        add(0, 1, 8'hFF, 0, 1, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1, 1, 0, 0, 0);
        // fresh 81 -> 1,0,0,0,0,0,0,1
        add(1, 1, 8'h81, 0, 1, 1, 1, 1, 0);
        for (int k = 0; k < 6; k++) add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 1, 1);
        add(1, 0, 8'h00, 0, 1, 1, 0, 1, 0);
`else
        // 07 -> 0,0,0,0,0,1,1,1 then parity 1
        add(1, 1, 8'h07, 0, 1, 1, 1, 0, 0);
        for (int k = 0; k < 4; k++) add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 8'h00, 0, 1, 0, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 1, 1);
        add(1, 0, 8'h00, 0, 1, 1, 0, 1, 0);
        // B4 has even weight: parity 0
        add(1, 1, 8'hB4, 0, 1, 1, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 1, 0, 1);
        add(1, 0, 8'h00, 0, 1, 1, 0, 0, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; valid_m = vecs[i].vin; data_m = vecs[i].data; pause_m = vecs[i].pause;
            #1;
            if (vecs[i].chk_rdy) chk($sformatf("vec%0d.ready", i), ready_m, vecs[i].rdy);
            @(posedge clk); #1;
            chk($sformatf("vec%0d.valid", i), vo_m, vecs[i].v);
            chk($sformatf("vec%0d.d", i), d_m, vecs[i].d);
            chk($sformatf("vec%0d.last", i), last_m, vecs[i].l);
        end

        // LSB-first instance: 01 -> 1 then seven 0s (plus parity 1 when enabled)
        @(negedge clk);
        valid_m = 1'b0; pause_m = 1'b0;
        data_l = 8'h01; valid_l = 1'b1;
        #1 chk("lsb.ready0", ready_l, 1'b1);
        @(posedge clk); #1;
        chk("lsb.v0", vo_l, 1'b1);
        chk("lsb.d0", d_l, 1'b1);
        chk("lsb.l0", last_l, 1'b0);
        @(negedge clk);
        valid_l = 1'b0; data_l = 8'h00;
        for (int k = 1; k < 8; k++) begin
            #1 chk($sformatf("lsb.ready%0d", k), ready_l, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("lsb.v%0d", k), vo_l, 1'b1);
            chk($sformatf("lsb.d%0d", k), d_l, 1'b0);
`ifdef BIT_SERIALIZER_PARITY_EN
            chk($sformatf("lsb.l%0d", k), last_l, 1'b0);
`else
            chk($sformatf("lsb.l%0d", k), last_l, (k == 7) ? 1'b1 : 1'b0);
`endif
            @(negedge clk);
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        @(posedge clk); #1;
        chk("lsb.vpar", vo_l, 1'b1);
        chk("lsb.dpar", d_l, 1'b1);
        chk("lsb.lpar", last_l, 1'b1);
        @(negedge clk);
`endif
        #1 chk("lsb.ready_end", ready_l, 1'b1);
        @(posedge clk); #1;
        chk("lsb.v_end", vo_l, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
